// File: rtl/data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : data_mem_responder                                              |
// | Purpose  : Multi-cycle word-addressed data memory serving one CPU load/store|
// |            at a time over valid/ready request and response channels.      |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module data_mem_responder #(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_write,
  input  logic [63:0]       i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_resp_err
);

  localparam int         c_AW   = $clog2(DEPTH);
  localparam logic [3:0] c_LAT  = 4'(LATENCY);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_WAIT = 2'd1;
  localparam logic [1:0] c_RESP = 2'd2;

  generate
    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
      $error("LATENCY must be in 0..15");
    end
    if ((1 << c_AW) != DEPTH) begin : g_bad_depth
      $error("DEPTH must be a power of two");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_inc;
  logic              r_write;
  logic [63:0]       r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_resp_done;
  logic              w_op_write;
  logic [63:0]       w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;
  logic              w_err;
  logic [c_AW-1:0]   w_idx;

  assign w_accept    = (r_state == c_IDLE) && i_req_valid;
  assign w_resp_done = (r_state == c_RESP) && i_resp_ready;
  assign w_cnt_inc   = r_cnt + 4'd1;

  // With zero latency the access happens on the accept edge, so the operation
  // must come straight from the request port instead of the capture registers.
  assign w_op_write  = (r_state == c_IDLE) ? i_req_write : r_write;
  assign w_op_addr   = (r_state == c_IDLE) ? i_req_addr  : r_addr;
  assign w_op_wdata  = (r_state == c_IDLE) ? i_req_wdata : r_wdata;

  assign w_err = (|w_op_addr[2:0]) || (|w_op_addr[63:c_AW+3]);
  assign w_idx = w_op_addr[3 +: c_AW];

  assign w_enter_resp = (w_state_nxt == c_RESP) && (r_state != c_RESP);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE: begin
        if (i_req_valid) begin
          w_state_nxt = (c_LAT == 4'd0) ? c_RESP : c_WAIT;
        end
      end
      c_WAIT: begin
        if (w_cnt_inc == c_LAT) begin
          w_state_nxt = c_RESP;
        end
      end
      c_RESP: begin
        if (i_resp_ready) begin
          w_state_nxt = c_IDLE;
        end
      end
      default: w_state_nxt = c_IDLE;
    endcase
  end

  always_comb begin
    o_req_ready  = (r_state == c_IDLE);
    o_resp_valid = (r_state == c_RESP);
    o_resp_rdata = r_rdata;
    o_resp_err   = r_err;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt   <= 4'd0;
      r_write <= 1'b0;
      r_addr  <= 64'd0;
      r_wdata <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'd0;
        r_write <= i_req_write;
        r_addr  <= i_req_addr;
        r_wdata <= i_req_wdata;
      end else if (r_state == c_WAIT) begin
        r_cnt <= w_cnt_inc;
      end

      if (w_enter_resp) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_op_write) ? '0 : r_mem[w_idx];
      end else if (w_resp_done) begin
        r_err   <= 1'b0;
        r_rdata <= '0;
      end
    end
  end

  // Stores commit on the edge entering RESP; a reset on that edge suppresses them.
  always_ff @(posedge i_clk) begin
    if (!i_reset && w_enter_resp && w_op_write && !w_err) begin
      r_mem[w_idx] <= w_op_wdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_data_mem_responder                                           |
// | Purpose  : Directed bench for data_mem_responder (LATENCY 2 and 0 copies).  |
// | Revision : 1.0                                                            |
// +----------------------------------------------------------------------------+
module tb_data_mem_responder;

  logic        clk;
  logic        rst        [2];
  logic        req_valid  [2];
  logic        req_ready  [2];
  logic        req_write  [2];
  logic [63:0] req_addr   [2];
  logic [63:0] req_wdata  [2];
  logic        resp_valid [2];
  logic        resp_ready [2];
  logic [63:0] resp_rdata [2];
  logic        resp_err   [2];

  int nvec  = 0;
  int nfail = 0;
  int cyc   = 0;
  int c_lat [2] = '{2, 0};

  data_mem_responder #(.DATA_W(64), .DEPTH(256), .LATENCY(2)) u_dut_l2 (
    .i_clk(clk), .i_reset(rst[0]),
    .i_req_valid(req_valid[0]), .o_req_ready(req_ready[0]),
    .i_req_write(req_write[0]), .i_req_addr(req_addr[0]), .i_req_wdata(req_wdata[0]),
    .o_resp_valid(resp_valid[0]), .i_resp_ready(resp_ready[0]),
    .o_resp_rdata(resp_rdata[0]), .o_resp_err(resp_err[0])
  );

  data_mem_responder #(.DATA_W(64), .DEPTH(256), .LATENCY(0)) u_dut_l0 (
    .i_clk(clk), .i_reset(rst[1]),
    .i_req_valid(req_valid[1]), .o_req_ready(req_ready[1]),
    .i_req_write(req_write[1]), .i_req_addr(req_addr[1]), .i_req_wdata(req_wdata[1]),
    .o_resp_valid(resp_valid[1]), .i_resp_ready(resp_ready[1]),
    .o_resp_rdata(resp_rdata[1]), .o_resp_err(resp_err[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: a request accepted at edge k is answered at edge
  // k+latency, where the access is performed against a plain memory array.
  bit          m_ok   [2];
  bit          m_pend [2];
  bit          m_resp [2];
  int          m_dead [2];
  bit          m_wr   [2];
  logic [63:0] m_addr [2];
  logic [63:0] m_wd   [2];
  logic [63:0] m_rdata[2];
  bit          m_err  [2];
  logic [63:0] m_mem  [2][256];

  always @(posedge clk) begin
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_ok[d] = 1'b1; m_pend[d] = 1'b0; m_resp[d] = 1'b0;
        m_rdata[d] = 64'd0; m_err[d] = 1'b0;
      end else begin
        if (m_resp[d]) begin
          if (resp_ready[d]) begin
            m_resp[d] = 1'b0; m_rdata[d] = 64'd0; m_err[d] = 1'b0;
          end
        end else if (!m_pend[d] && req_valid[d]) begin
          m_pend[d] = 1'b1; m_dead[d] = cyc + c_lat[d];
          m_wr[d] = req_write[d]; m_addr[d] = req_addr[d]; m_wd[d] = req_wdata[d];
        end
        if (m_pend[d] && cyc == m_dead[d]) begin
          m_pend[d] = 1'b0;
          m_resp[d] = 1'b1;
          m_err[d]  = (m_addr[d] % 8 != 0) || (m_addr[d] >= 64'd2048);
          m_rdata[d] = 64'd0;
          if (!m_err[d]) begin
            if (m_wr[d]) m_mem[d][m_addr[d] / 8] = m_wd[d];
            else         m_rdata[d] = m_mem[d][m_addr[d] / 8];
          end
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (m_ok[d]) begin
        chk($sformatf("mdl_req_ready[%0d]", d), 64'(req_ready[d]), 64'(!(m_pend[d] || m_resp[d])));
        chk($sformatf("mdl_resp_valid[%0d]", d), 64'(resp_valid[d]), 64'(m_resp[d]));
        chk($sformatf("mdl_resp_rdata[%0d]", d), resp_rdata[d], m_rdata[d]);
        chk($sformatf("mdl_resp_err[%0d]", d), 64'(resp_err[d]), 64'(m_err[d]));
      end
    end
  end

  // One request; bp cycles of response backpressure during which a stray
  // request is presented and must be ignored.
  task automatic xact(input int d, input bit wr, input logic [63:0] a, input logic [63:0] wd,
                      input int bp, output logic [63:0] rd, output bit er, output int lat);
    int n;
    @(negedge clk);
    n = 0;
    while (!req_ready[d] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("req_ready_timeout", 64'(n < 50), 64'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    resp_ready[d] = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      req_valid[d] = 1'b0;
    end while (!resp_valid[d] && lat < 50);
    chk("resp_timeout", 64'(resp_valid[d]), 64'd1);
    rd = resp_rdata[d];
    er = resp_err[d];
    for (int i = 0; i < bp; i++) begin
      req_valid[d] = 1'b1; req_write[d] = 1'b1; req_wdata[d] = ~wd;
      @(negedge clk);
      chk("bp_req_ready", 64'(req_ready[d]), 64'd0);
      chk("bp_resp_valid", 64'(resp_valid[d]), 64'd1);
      chk("bp_resp_rdata", resp_rdata[d], rd);
    end
    req_valid[d] = 1'b0;
    resp_ready[d] = 1'b1;
    @(negedge clk);
    resp_ready[d] = 1'b0;
  endtask

  logic [63:0] rd;
  bit          er;
  int          lat;
  logic [63:0] got [4];
  int          at  [4];
  logic [63:0] ord [4] = '{64'h18, 64'h00, 64'h10, 64'h08};
  logic [63:0] val [4] = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                           64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};
  int          k, nr, t;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; req_valid[d] = 1'b0; req_write[d] = 1'b0;
      req_addr[d] = 64'd0; req_wdata[d] = 64'd0; resp_ready[d] = 1'b0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_req_ready", 64'(req_ready[d]), 64'd1);
      chk("rst_resp_valid", 64'(resp_valid[d]), 64'd0);
      chk("rst_resp_rdata", resp_rdata[d], 64'd0);
      chk("rst_resp_err", 64'(resp_err[d]), 64'd0);
    end
    rst[0] = 1'b0; rst[1] = 1'b0;

    xact(0, 1'b1, 64'h10, 64'hDEADBEEF_CAFEF00D, 0, rd, er, lat);
    chk("st_latency", 64'(lat), 64'd3);
    chk("st_rdata", rd, 64'd0);
    chk("st_err", 64'(er), 64'd0);
    xact(0, 1'b0, 64'h10, 64'd0, 0, rd, er, lat);
    chk("ld_latency", 64'(lat), 64'd3);
    chk("ld_rdata", rd, 64'hDEADBEEF_CAFEF00D);

    xact(0, 1'b0, 64'h10, 64'd0, 5, rd, er, lat);
    chk("bp_ld_rdata", rd, 64'hDEADBEEF_CAFEF00D);
    xact(0, 1'b0, 64'h10, 64'd0, 0, rd, er, lat);
    chk("ignored_req_rdata", rd, 64'hDEADBEEF_CAFEF00D);

    xact(0, 1'b1, 64'h08, 64'hA5A5A5A5_5A5A5A5A, 0, rd, er, lat);
    xact(0, 1'b1, 64'h0C, 64'h1111_1111_1111_1111, 0, rd, er, lat);
    chk("misalign_err", 64'(er), 64'd1);
    chk("misalign_rdata", rd, 64'd0);
    xact(0, 1'b0, 64'h800, 64'd0, 0, rd, er, lat);
    chk("range_err", 64'(er), 64'd1);
    chk("range_rdata", rd, 64'd0);
    chk("range_latency", 64'(lat), 64'd3);
    xact(0, 1'b0, 64'h08, 64'd0, 0, rd, er, lat);
    chk("after_err_rdata", rd, 64'hA5A5A5A5_5A5A5A5A);
    chk("after_err_err", 64'(er), 64'd0);

    xact(0, 1'b1, 64'h20, 64'h5555_6666_7777_8888, 0, rd, er, lat);
    @(negedge clk);
    req_valid[0] = 1'b1; req_write[0] = 1'b1; req_addr[0] = 64'h20; req_wdata[0] = 64'h1234;
    @(negedge clk);
    req_valid[0] = 1'b0;
    chk("midop_in_wait", 64'(req_ready[0]), 64'd0);
    rst[0] = 1'b1;
    @(negedge clk);
    rst[0] = 1'b0;
    chk("midop_idle_ready", 64'(req_ready[0]), 64'd1);
    chk("midop_idle_valid", 64'(resp_valid[0]), 64'd0);
    xact(0, 1'b0, 64'h20, 64'd0, 0, rd, er, lat);
    chk("midop_old_value", rd, 64'h5555_6666_7777_8888);

    for (int i = 0; i < 4; i++) begin
      xact(1, 1'b1, 64'(i * 8), val[i], 0, rd, er, lat);
      chk("l0_st_latency", 64'(lat), 64'd1);
    end
    @(negedge clk);
    resp_ready[1] = 1'b1;
    k = 0; nr = 0; t = 0;
    while (nr < 4 && t < 60) begin
      @(negedge clk);
      t++;
      if (resp_valid[1]) begin
        got[nr] = resp_rdata[1];
        at[nr]  = t;
        nr++;
      end
      if (req_ready[1] && k < 4) begin
        req_valid[1] = 1'b1; req_write[1] = 1'b0; req_addr[1] = ord[k];
        k++;
      end else begin
        req_valid[1] = 1'b0;
      end
    end
    req_valid[1] = 1'b0;
    resp_ready[1] = 1'b0;
    chk("b2b_count", 64'(nr), 64'd4);
    for (int i = 0; i < nr; i++) begin
      chk($sformatf("b2b_rdata[%0d]", i), got[i], val[ord[i] / 8]);
      if (i > 0) chk($sformatf("b2b_gap[%0d]", i), 64'(at[i] - at[i-1]), 64'd2);
    end
    chk("b2b_first_literal", got[0], 64'h4444_0000_0000_0004);

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    nfail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
`default_nettype wire
